// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: op codes, rounding modes,
// controller states and fflags bit positions.
package fpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_SUB      = 5'b00001;
    localparam logic [4:0] OP_MUL      = 5'b00010;
    localparam logic [4:0] OP_DIV      = 5'b00011;
    localparam logic [4:0] OP_SGNJ     = 5'b00100;
    localparam logic [4:0] OP_MINMAX   = 5'b00101;
    localparam logic [4:0] OP_SQRT     = 5'b01011;
    localparam logic [4:0] OP_CMP      = 5'b10100;
    localparam logic [4:0] OP_CVT_W    = 5'b11000;
    localparam logic [4:0] OP_CVT_S    = 5'b11010;
    localparam logic [4:0] OP_CLASS_MV = 5'b11100;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    // Only these ops consume a rounding mode; for the rest the field is funct3.
    function automatic logic is_rounding_op(input logic [4:0] op);
        logic rnd;
        rnd = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQRT, OP_CVT_W, OP_CVT_S: rnd = 1'b1;
            default: rnd = 1'b0;
        endcase
        return rnd;
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves the instruction rounding-mode field against fcsr.frm and flags
// reserved rounding modes for ops that actually round.
module fpu_rm_resolve
    import fpu_ctrl_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic [2:0] rm_i,
    input  logic [2:0] frm_i,
    output logic [2:0] rm_o,
    output logic       illegal_o
);

    logic [2:0] rm_res;

    always_comb begin
        rm_res    = rm_i;
        illegal_o = 1'b0;
        if (is_rounding_op(op_i)) begin
            if (rm_i == RM_DYN) begin
                rm_res = frm_i;
            end
            illegal_o = (rm_res == 3'b101) || (rm_res == 3'b110) || (rm_res == 3'b111);
        end
        rm_o = rm_res;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer in front of the FPU arithmetic unit: accept, execute with a
// watchdog, hand the result to writeback and accumulate sticky fflags.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_rs2_lsb,
    input  logic [4:0]  req_rd,
    input  logic        req_wb_int,
    input  logic [2:0]  frm_i,

    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_out,
    input  logic        fpu_done,
    input  logic        fpu_nv,
    input  logic        fpu_dz,
    input  logic        fpu_of,
    input  logic        fpu_uf,
    input  logic        fpu_nx,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_wb_int,
    output logic        rsp_illegal,
    output logic        rsp_timeout,

    input  logic        fflags_we,
    input  logic [4:0]  fflags_wdata,
    output logic [4:0]  fflags_o,
    output logic        busy
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic              req_ready_q;
    logic              fpu_start_q;
    logic [4:0]        fpu_op_q;
    logic [2:0]        fpu_rm_q;
    logic [31:0]       fpu_a_q;
    logic [31:0]       fpu_b_q;
    logic              fpu_rs2_lsb_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_wb_int_q;
    logic              rsp_illegal_q;
    logic              rsp_timeout_q;
    logic [4:0]        pend_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        fflags_q;
    logic [4:0]        fflags_d;

    logic [2:0]        rm_res;
    logic              rm_illegal;
    logic [4:0]        flags_in;
    logic              rsp_hs;
    logic [4:0]        pend_eff;

    fpu_rm_resolve u_rm_resolve (
        .op_i      (req_op),
        .rm_i      (req_rm),
        .frm_i     (frm_i),
        .rm_o      (rm_res),
        .illegal_o (rm_illegal)
    );

    always_comb begin
        flags_in          = '0;
        flags_in[FLAG_NV] = fpu_nv;
        flags_in[FLAG_DZ] = fpu_dz;
        flags_in[FLAG_OF] = fpu_of;
        flags_in[FLAG_UF] = fpu_uf;
        flags_in[FLAG_NX] = fpu_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            fpu_start_q   <= 1'b0;
            fpu_op_q      <= '0;
            fpu_rm_q      <= '0;
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_rs2_lsb_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rd_q      <= '0;
            rsp_wb_int_q  <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            pend_q        <= '0;
            cnt_q         <= '0;
        end else if (flush) begin
            // Flush wins over everything, including a request in the same cycle.
            state_q       <= StIdle;
            req_ready_q   <= 1'b1;
            fpu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_timeout_q <= 1'b0;
            pend_q        <= '0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        fpu_op_q      <= req_op;
                        fpu_rm_q      <= rm_res;
                        fpu_a_q       <= req_a;
                        fpu_b_q       <= req_b;
                        fpu_rs2_lsb_q <= req_rs2_lsb;
                        rsp_rd_q      <= req_rd;
                        rsp_wb_int_q  <= req_wb_int;
                        req_ready_q   <= 1'b0;
                        pend_q        <= '0;
                        cnt_q         <= '0;
                        if (rm_illegal) begin
                            state_q       <= StResp;
                            rsp_valid_q   <= 1'b1;
                            rsp_illegal_q <= 1'b1;
                            rsp_data_q    <= '0;
                        end else begin
                            state_q     <= StExec;
                            fpu_start_q <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    if (fpu_done) begin
                        state_q     <= StResp;
                        fpu_start_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= fpu_out;
                        pend_q      <= flags_in;
                    end else if (cnt_q == CntLast) begin
                        state_q       <= StResp;
                        fpu_start_q   <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        pend_q        <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q       <= StIdle;
                        req_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b0;
                        rsp_illegal_q <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        pend_q        <= '0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                    fpu_start_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_hs   = (state_q == StResp) && rsp_ready && !flush;
    assign pend_eff = (rsp_illegal_q || rsp_timeout_q) ? 5'b00000 : pend_q;

    always_comb begin
        fflags_d = fflags_q;
        if (fflags_we) begin
            fflags_d = fflags_wdata | (rsp_hs ? pend_eff : 5'b00000);
        end else if (rsp_hs) begin
            fflags_d = fflags_q | pend_eff;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign fpu_start   = fpu_start_q;
    assign fpu_op      = fpu_op_q;
    assign fpu_rm      = fpu_rm_q;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_rs2_lsb = fpu_rs2_lsb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_wb_int  = rsp_wb_int_q;
    assign rsp_illegal = rsp_illegal_q;
    assign rsp_timeout = rsp_timeout_q;
    assign fflags_o    = fflags_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a latency-programmable arithmetic stub.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [2:0]  req_rm = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_rs2_lsb = 1'b0;
    logic [4:0]  req_rd = '0;
    logic        req_wb_int = 1'b0;
    logic [2:0]  frm = '0;
    logic        fpu_start;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic        fpu_rs2_lsb;
    logic [31:0] fpu_out;
    logic        fpu_done;
    logic        fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_wb_int;
    logic        rsp_illegal;
    logic        rsp_timeout;
    logic        fflags_we = 1'b0;
    logic [4:0]  fflags_wdata = '0;
    logic [4:0]  fflags_o;
    logic        busy;

    // Arithmetic stub: done after stub_lat consecutive start cycles.
    logic        stub_en = 1'b1;
    int          stub_lat = 1;
    logic [31:0] stub_out = '0;
    logic [4:0]  stub_flags = '0;
    int          start_cnt = 0;
    int          start_hi = 0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fpu_start) begin
            start_cnt <= start_cnt + 1;
            start_hi  <= start_hi + 1;
        end else begin
            start_cnt <= 0;
        end
    end

    assign fpu_done = stub_en && fpu_start && (start_cnt == stub_lat - 1);
    assign fpu_out  = stub_out;
    assign {fpu_nv, fpu_dz, fpu_of, fpu_uf, fpu_nx} = stub_flags;

    fpu_issue_ctrl #(
        .TIMEOUT_CYCLES (64),
        .CNT_W          (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rm       (req_rm),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_rs2_lsb  (req_rs2_lsb),
        .req_rd       (req_rd),
        .req_wb_int   (req_wb_int),
        .frm_i        (frm),
        .fpu_start    (fpu_start),
        .fpu_op       (fpu_op),
        .fpu_rm       (fpu_rm),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_rs2_lsb  (fpu_rs2_lsb),
        .fpu_out      (fpu_out),
        .fpu_done     (fpu_done),
        .fpu_nv       (fpu_nv),
        .fpu_dz       (fpu_dz),
        .fpu_of       (fpu_of),
        .fpu_uf       (fpu_uf),
        .fpu_nx       (fpu_nx),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rd       (rsp_rd),
        .rsp_wb_int   (rsp_wb_int),
        .rsp_illegal  (rsp_illegal),
        .rsp_timeout  (rsp_timeout),
        .fflags_we    (fflags_we),
        .fflags_wdata (fflags_wdata),
        .fflags_o     (fflags_o),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accepting edge; returns in cycle 1.
    task automatic issue(input logic [4:0] op, input logic [2:0] rm, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic wb_int);
        req_valid  = 1'b1;
        req_op     = op;
        req_rm     = rm;
        req_a      = a;
        req_b      = b;
        req_rd     = rd;
        req_wb_int = wb_int;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;

        // Reset state
        step();
        step();
        check("rst_req_ready", req_ready, 1);
        check("rst_fpu_start", fpu_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fflags", fflags_o, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        step();

        // ADD, single-cycle stub
        stub_en = 1'b1; stub_lat = 1; stub_out = 32'h4040_0000; stub_flags = 5'b00000;
        rsp_ready = 1'b1;
        base = start_hi;
        issue(5'b00000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1'b0);
        check("add_c1_start", fpu_start, 1);
        check("add_c1_busy", busy, 1);
        check("add_c1_req_ready", req_ready, 0);
        check("add_c1_rsp_valid", rsp_valid, 0);
        check("add_c1_fpu_a", fpu_a, 32'h3F80_0000);
        check("add_c1_fpu_b", fpu_b, 32'h4000_0000);
        step();
        check("add_c2_rsp_valid", rsp_valid, 1);
        check("add_c2_rsp_data", rsp_data, 32'h4040_0000);
        check("add_c2_rsp_rd", rsp_rd, 7);
        check("add_c2_start", fpu_start, 0);
        step();
        check("add_c3_rsp_valid", rsp_valid, 0);
        check("add_c3_req_ready", req_ready, 1);
        check("add_start_cycles", start_hi - base, 1);
        check("add_fflags", fflags_o, 5'b00000);

        // DIV with dynamic rm, 20-cycle stub, DZ+NX
        stub_lat = 20; stub_out = 32'h3F00_0000; stub_flags = 5'b01001;
        frm = 3'b001;
        base = start_hi;
        issue(5'b00011, 3'b111, 32'h3F80_0000, 32'h4000_0000, 5'd3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("div_rm", fpu_rm, 3'b001);
            check("div_start", fpu_start, 1);
            step();
        end
        check("div_rsp_valid", rsp_valid, 1);
        check("div_rsp_data", rsp_data, 32'h3F00_0000);
        check("div_start_cycles", start_hi - base, 20);
        step();
        check("div_fflags", fflags_o, 5'b01001);

        // MUL with dynamic rm resolving to reserved 101
        frm = 3'b101; stub_lat = 1; stub_flags = 5'b10000;
        base = start_hi;
        issue(5'b00010, 3'b111, 32'h1, 32'h2, 5'd4, 1'b0);
        check("mul_illegal", rsp_illegal, 1);
        check("mul_rsp_valid", rsp_valid, 1);
        check("mul_rsp_data", rsp_data, 0);
        check("mul_start", fpu_start, 0);
        step();
        check("mul_illegal_clr", rsp_illegal, 0);
        check("mul_no_start", start_hi - base, 0);
        check("mul_fflags", fflags_o, 5'b01001);

        // Non-rounding op: rm=111 passes through as funct3
        stub_flags = 5'b00000; stub_out = 32'hABCD_0000;
        issue(5'b00100, 3'b111, 32'h5, 32'h6, 5'd9, 1'b0);
        check("sgnj_rm_pass", fpu_rm, 3'b111);
        check("sgnj_start", fpu_start, 1);
        step();
        check("sgnj_illegal", rsp_illegal, 0);
        check("sgnj_rsp_data", rsp_data, 32'hABCD_0000);
        step();

        // SQRT that never completes: watchdog after 64 EXEC cycles
        stub_en = 1'b0; stub_out = 32'hDEAD_BEEF; stub_flags = 5'b11111; frm = 3'b000;
        base = start_hi;
        issue(5'b01011, 3'b000, 32'h4080_0000, 32'h0, 5'd2, 1'b0);
        cyc = 1;
        while (!rsp_valid && cyc < 200) begin
            step();
            cyc++;
        end
        check("sqrt_rsp_cycle", cyc, 65);
        check("sqrt_timeout", rsp_timeout, 1);
        check("sqrt_rsp_data", rsp_data, 0);
        check("sqrt_start_cycles", start_hi - base, 64);
        step();
        check("sqrt_timeout_clr", rsp_timeout, 0);
        check("sqrt_fflags", fflags_o, 5'b01001);

        // Flush during EXEC with a concurrent request
        stub_en = 1'b1; stub_lat = 10; stub_flags = 5'b10100; stub_out = 32'h1111_1111;
        issue(5'b00000, 3'b000, 32'h1, 32'h1, 5'd5, 1'b0);
        step();
        check("flush_pre_busy", busy, 1);
        flush = 1'b1;
        req_valid = 1'b1; req_op = 5'b00010; req_rm = 3'b000;
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_start", fpu_start, 0);
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_req_ready", req_ready, 1);
        step();
        check("flush_not_accepted", busy, 0);
        check("flush_fflags", fflags_o, 5'b01001);
        stub_lat = 1; stub_flags = 5'b00000; stub_out = 32'h4040_0000;
        issue(5'b00000, 3'b000, 32'h3F80_0000, 32'h4000_0000, 5'd6, 1'b1);
        step();
        check("post_flush_valid", rsp_valid, 1);
        check("post_flush_data", rsp_data, 32'h4040_0000);
        check("post_flush_wb_int", rsp_wb_int, 1);
        step();
        check("post_flush_fflags", fflags_o, 5'b01001);

        // Backpressure on the response, CSR write coincident with handshake
        stub_flags = 5'b00001; stub_out = 32'h1234_5678;
        rsp_ready = 1'b0;
        issue(5'b00001, 3'b010, 32'h2, 32'h3, 5'd11, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", rsp_valid, 1);
            check("bp_data", rsp_data, 32'h1234_5678);
            check("bp_rd", rsp_rd, 11);
            check("bp_req_ready", req_ready, 0);
            step();
        end
        check("bp_fflags_hold", fflags_o, 5'b01001);
        rsp_ready = 1'b1;
        fflags_we = 1'b1; fflags_wdata = 5'b10000;
        step();
        fflags_we = 1'b0;
        check("bp_fflags", fflags_o, 5'b10001);
        check("bp_done_valid", rsp_valid, 0);

        // Lone CSR write overwrites the sticky flags
        fflags_we = 1'b1; fflags_wdata = 5'b00110;
        step();
        fflags_we = 1'b0;
        check("csr_write", fflags_o, 5'b00110);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
